axi_wr_sched_2to1: RTL and testbench

Write-channel scheduler for the R52 cluster's 2-to-1 AXI4 write path to the NoC. It arbitrates AW requests from Core0 and Core1 round-robin and holds each grant stable until its handshake completes. It records granted master order in a W-order FIFO and steers W beats strictly in that order. It routes B responses by master tag and tracks per-master outstanding writes. It produces select and handshake signals only; payload muxing stays in the interconnect datapath.

---
 rtl/axi_wr_sched_2to1_if.sv | 54 +++++
 rtl/axi_wr_sched_2to1.sv | 174 +++++++++++++++++
 tb/tb_axi_wr_sched_2to1.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_sched_2to1_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_wr_sched_2to1_if
//  Brief    : Handshake/select bundle for the 2-to-1 AXI write scheduler.
//             s_awqos exists only when AXI_WR_SCHED_QOS_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface axi_wr_sched_2to1_if;
    logic [1:0]      s_awvalid;
    logic [1:0]      s_awready;
    logic            m_awvalid;
    logic            m_awready;
    logic            aw_sel;
    logic [1:0]      s_wvalid;
    logic [1:0]      s_wlast;
    logic [1:0]      s_wready;
    logic            m_wvalid;
    logic            m_wlast;
    logic            m_wready;
    logic            w_sel;
    logic            m_bvalid;
    logic            b_tag;
    logic            m_bready;
    logic [1:0]      s_bvalid;
    logic [1:0]      s_bready;
    logic [1:0][7:0] osd_cnt;
    logic            err_unexp_b;
`ifdef AXI_WR_SCHED_QOS_EN
    logic [1:0][3:0] s_awqos;
`endif

    // Scheduler view
    modport slave (
`ifdef AXI_WR_SCHED_QOS_EN
        input  s_awqos,
`endif
        input  s_awvalid, m_awready, s_wvalid, s_wlast, m_wready,
        input  m_bvalid, b_tag, s_bready,
        output s_awready, m_awvalid, aw_sel, s_wready, m_wvalid, m_wlast, w_sel,
        output m_bready, s_bvalid, osd_cnt, err_unexp_b
    );

    // Environment view (cores + NoC)
    modport master (
`ifdef AXI_WR_SCHED_QOS_EN
        output s_awqos,
`endif
        output s_awvalid, m_awready, s_wvalid, s_wlast, m_wready,
        output m_bvalid, b_tag, s_bready,
        input  s_awready, m_awvalid, aw_sel, s_wready, m_wvalid, m_wlast, w_sel,
        input  m_bready, s_bvalid, osd_cnt, err_unexp_b
    );
endinterface
`default_nettype wire

// File: rtl/axi_wr_sched_2to1.sv
`default_nettype none
// ============================================================================
//  Module   : axi_wr_sched_2to1
//  Brief    : Round-robin AW arbiter with grant lock, W-order FIFO steering,
//             B routing and per-master outstanding counters.
//             Optional macro AXI_WR_SCHED_QOS_EN adds QoS-priority arbitration.
//  Revision : 1.0  initial release
// ============================================================================
module axi_wr_sched_2to1 #(
    parameter int NUM_MASTERS     = 2,
    parameter int WFIFO_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                clk,
    input  logic                rst,
    axi_wr_sched_2to1_if.slave  bus
);

    localparam int c_PTR_W = $clog2(WFIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(WFIFO_DEPTH);
    localparam logic [7:0]         c_MAX_OSD   = 8'(MAX_OUTSTANDING);

    logic                          r_rr_ptr;
    logic                          r_lock;
    logic                          r_lock_sel;
    logic [WFIFO_DEPTH-1:0]        r_fifo;
    logic [c_PTR_W-1:0]            r_wr_ptr;
    logic [c_PTR_W-1:0]            r_rd_ptr;
    logic [c_CNT_W-1:0]            r_fcnt;
    logic                          r_full;
    logic [NUM_MASTERS-1:0][7:0]   r_osd;
    logic                          r_err;

    logic [NUM_MASTERS-1:0]        w_elig;
    logic                          w_gnt_idx;
    logic                          w_gnt_vld;
    logic                          w_aw_hs;
    logic [1:0]                    w_s_awready;
    logic                          w_head;
    logic                          w_wact;
    logic                          w_m_wvalid;
    logic                          w_m_wlast;
    logic [1:0]                    w_s_wready;
    logic                          w_pop;
    logic [c_CNT_W-1:0]            w_fcnt_nxt;
    logic                          w_b_en;
    logic [1:0]                    w_s_bvalid;
    logic                          w_m_bready;
    logic                          w_b_hs;
    logic                          w_unexp;
    logic [NUM_MASTERS-1:0]        w_inc;
    logic [NUM_MASTERS-1:0]        w_dec;

    // AW arbitration; a locked grant bypasses eligibility entirely
    always_comb begin
        w_gnt_idx = r_rr_ptr;
        w_gnt_vld = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_elig[i] = bus.s_awvalid[i] && !r_full && (r_osd[i] < c_MAX_OSD);
        end
        if (r_lock) begin
            w_gnt_idx = r_lock_sel;
            w_gnt_vld = bus.s_awvalid[r_lock_sel];
        end else begin
            if (w_elig[r_rr_ptr]) begin
                w_gnt_idx = r_rr_ptr;
            end else if (w_elig[~r_rr_ptr]) begin
                w_gnt_idx = ~r_rr_ptr;
            end
`ifdef AXI_WR_SCHED_QOS_EN
            if ((&w_elig) && (bus.s_awqos[0] != bus.s_awqos[1])) begin
                w_gnt_idx = (bus.s_awqos[1] > bus.s_awqos[0]);
            end
`endif
            w_gnt_vld = |w_elig;
        end
        if (rst) begin
            w_gnt_idx = 1'b0;
            w_gnt_vld = 1'b0;
        end
    end

    assign w_aw_hs = w_gnt_vld && bus.m_awready;

    always_comb begin
        w_s_awready            = '0;
        w_s_awready[w_gnt_idx] = w_gnt_vld && bus.m_awready;
    end

    assign bus.m_awvalid = w_gnt_vld;
    assign bus.aw_sel    = w_gnt_idx;
    assign bus.s_awready = w_s_awready;

    // W steering from the FIFO head
    assign w_head     = r_fifo[r_rd_ptr];
    assign w_wact     = !rst && (r_fcnt != '0);
    assign w_m_wvalid = w_wact && bus.s_wvalid[w_head];
    assign w_m_wlast  = w_wact && bus.s_wlast[w_head];
    assign w_pop      = w_m_wvalid && bus.m_wready && w_m_wlast;
    assign w_fcnt_nxt = r_fcnt + c_CNT_W'(w_aw_hs) - c_CNT_W'(w_pop);

    always_comb begin
        w_s_wready         = '0;
        w_s_wready[w_head] = w_wact && bus.m_wready;
    end

    assign bus.w_sel    = w_wact && w_head;
    assign bus.m_wvalid = w_m_wvalid;
    assign bus.m_wlast  = w_m_wlast;
    assign bus.s_wready = w_s_wready;

    // B routing by returned tag
    assign w_b_en     = !rst;
    assign w_m_bready = w_b_en && bus.s_bready[bus.b_tag];
    assign w_b_hs     = w_b_en && bus.m_bvalid && bus.s_bready[bus.b_tag];
    assign w_unexp    = w_b_hs && (r_osd[bus.b_tag] == 8'd0);

    always_comb begin
        w_s_bvalid             = '0;
        w_s_bvalid[bus.b_tag]  = w_b_en && bus.m_bvalid;
    end

    assign bus.s_bvalid    = w_s_bvalid;
    assign bus.m_bready    = w_m_bready;
    assign bus.osd_cnt     = r_osd;
    assign bus.err_unexp_b = r_err;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_inc[i] = w_aw_hs && (w_gnt_idx == 1'(i));
            w_dec[i] = w_b_hs && (bus.b_tag == 1'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= 1'b0;
            r_lock     <= 1'b0;
            r_lock_sel <= 1'b0;
            r_fifo     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fcnt     <= '0;
            r_full     <= 1'b0;
            r_osd      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_lock     <= w_gnt_vld && !bus.m_awready;
            r_lock_sel <= w_gnt_idx;
            if (w_aw_hs) begin
                r_rr_ptr         <= ~w_gnt_idx;
                r_fifo[r_wr_ptr] <= w_gnt_idx;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_fcnt <= w_fcnt_nxt;
            r_full <= (w_fcnt_nxt == c_DEPTH_CNT);
            r_err  <= r_err || w_unexp;
            // Counter saturates at zero on an unexpected B
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_osd[i] <= r_osd[i] + 8'd1;
                end else if (w_dec[i] && !w_inc[i] && (r_osd[i] != 8'd0)) begin
                    r_osd[i] <= r_osd[i] - 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_sched_2to1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_wr_sched_2to1
//  Brief    : Directed bench with a queue-based reference model for the
//             2-to-1 AXI write scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_wr_sched_2to1;

    localparam int c_DEPTH = 4;
    localparam int c_MAXO  = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    axi_wr_sched_2to1_if bus ();

    axi_wr_sched_2to1 #(
        .NUM_MASTERS     (2),
        .WFIFO_DEPTH     (c_DEPTH),
        .MAX_OUTSTANDING (c_MAXO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: order queue, outstanding counts, preferred master
    // ------------------------------------------------------------------
    int q[$];
    int osd[2];
    int rr;
    bit locked;
    int lsel;
    bit err;

    initial begin
        int g, h, bt;
        bit v, full, aw_hs, w_pop, b_hs;
        bit el[2];
        int e_awr, e_wv, e_wl, e_wr, e_wsel, e_bv, e_br;
        q.delete();
        osd[0] = 0; osd[1] = 0; rr = 0; locked = 0; lsel = 0; err = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            g = rr; v = 0; e_awr = 0; e_wv = 0; e_wl = 0; e_wr = 0; e_wsel = 0; e_bv = 0; e_br = 0;
            if (!rst) begin
                full = (q.size() == c_DEPTH);
                if (locked) begin
                    g = lsel;
                    v = bus.s_awvalid[lsel];
                end else begin
                    for (int i = 0; i < 2; i++) el[i] = bus.s_awvalid[i] && !full && (osd[i] < c_MAXO);
                    if (el[rr]) g = rr;
                    else if (el[1-rr]) g = 1 - rr;
`ifdef AXI_WR_SCHED_QOS_EN
                    if (el[0] && el[1] && (bus.s_awqos[0] != bus.s_awqos[1]))
                        g = (bus.s_awqos[1] > bus.s_awqos[0]) ? 1 : 0;
`endif
                    v = el[0] || el[1];
                end
                if (v && bus.m_awready) e_awr = 1 << g;
                if (q.size() > 0) begin
                    h      = q[0];
                    e_wv   = bus.s_wvalid[h];
                    e_wl   = bus.s_wlast[h];
                    e_wr   = bus.m_wready ? (1 << h) : 0;
                    e_wsel = h;
                end
                e_bv = bus.m_bvalid ? (1 << bus.b_tag) : 0;
                e_br = bus.s_bready[bus.b_tag];
            end else begin
                g = 0;
            end
            chk("m_awvalid", bus.m_awvalid, v);
            if (v || rst) chk("aw_sel", bus.aw_sel, g);
            chk("s_awready", bus.s_awready, e_awr);
            chk("m_wvalid", bus.m_wvalid, e_wv);
            chk("m_wlast", bus.m_wlast, e_wl);
            chk("s_wready", bus.s_wready, e_wr);
            chk("w_sel", bus.w_sel, e_wsel);
            chk("s_bvalid", bus.s_bvalid, e_bv);
            chk("m_bready", bus.m_bready, e_br);
            chk("osd_cnt0", bus.osd_cnt[0], osd[0]);
            chk("osd_cnt1", bus.osd_cnt[1], osd[1]);
            chk("err_unexp_b", bus.err_unexp_b, err);

            @(posedge clk);
            if (rst) begin
                q.delete();
                osd[0] = 0; osd[1] = 0; rr = 0; locked = 0; lsel = 0; err = 0;
            end else begin
                aw_hs = v && bus.m_awready;
                w_pop = (q.size() > 0) && (e_wv != 0) && bus.m_wready && (e_wl != 0);
                bt    = bus.b_tag;
                b_hs  = bus.m_bvalid && bus.s_bready[bt];
                if (b_hs && osd[bt] == 0) err = 1;
                for (int i = 0; i < 2; i++) begin
                    if (aw_hs && g == i && !(b_hs && bt == i)) osd[i]++;
                    else if (b_hs && bt == i && !(aw_hs && g == i) && osd[i] > 0) osd[i]--;
                end
                if (w_pop) void'(q.pop_front());
                if (aw_hs) begin
                    q.push_back(g);
                    rr = 1 - g;
                end
                locked = v && !bus.m_awready;
                lsel   = g;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.s_awvalid = '0; bus.m_awready = 1'b0;
        bus.s_wvalid  = '0; bus.s_wlast   = '0; bus.m_wready = 1'b0;
        bus.m_bvalid  = 1'b0; bus.b_tag = 1'b0; bus.s_bready = '0;
`ifdef AXI_WR_SCHED_QOS_EN
        bus.s_awqos   = '0;
`endif
    endtask

    task automatic bret(input int tag);
        bus.m_bvalid = 1'b1; bus.b_tag = 1'(tag); bus.s_bready = 2'b11;
        cyc();
        bus.m_bvalid = 1'b0; bus.b_tag = 1'b0; bus.s_bready = '0;
    endtask

    task automatic wdrain(input int n);
        bus.s_wvalid = 2'b11; bus.s_wlast = 2'b11; bus.m_wready = 1'b1;
        repeat (n) cyc();
        bus.s_wvalid = '0; bus.s_wlast = '0; bus.m_wready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clr();
        bus.s_awvalid = 2'b11; bus.m_awready = 1'b1;
        bus.s_wvalid  = 2'b11; bus.s_wlast   = 2'b11; bus.m_wready = 1'b1;
        bus.m_bvalid  = 1'b1; bus.b_tag = 1'b1; bus.s_bready = 2'b11;
        cyc();
        #1;
        chk("rst_awvalid", bus.m_awvalid, 0);
        chk("rst_awready", bus.s_awready, 0);
        chk("rst_bvalid", bus.s_bvalid, 0);
        cyc();
        rst = 1'b0;
        clr();
        #1;
        chk("post_rst_osd0", bus.osd_cnt[0], 0);
        chk("post_rst_err", bus.err_unexp_b, 0);
        chk("post_rst_wsel", bus.w_sel, 0);
        cyc();

        // Both masters continuously requesting: strict alternation
        bus.s_awvalid = 2'b11; bus.m_awready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1; chk("t1_aw_sel", bus.aw_sel, k % 2);
            cyc();
        end
        bus.s_awvalid = '0;
        #1;
        chk("t1_osd0", bus.osd_cnt[0], 2);
        chk("t1_osd1", bus.osd_cnt[1], 2);
        bus.s_wvalid = 2'b11; bus.s_wlast = 2'b11; bus.m_wready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1; chk("t1_w_sel", bus.w_sel, k % 2);
            chk("t1_s_wready", bus.s_wready, 1 << (k % 2));
            cyc();
        end
        clr();
        bret(0); bret(1); bret(0); bret(1);
        #1; chk("t1_osd_drained", bus.osd_cnt, 0);

        // Grant lock while master 1 becomes preferred
        bus.s_awvalid = 2'b01; bus.m_awready = 1'b1;
        cyc();
        bus.m_awready = 1'b0;
        repeat (3) begin
            #1; chk("t2_hold_sel", bus.aw_sel, 0);
            chk("t2_hold_awready", bus.s_awready, 0);
            cyc();
        end
        bus.s_awvalid = 2'b11;
        #1; chk("t2_locked_sel", bus.aw_sel, 0);
        cyc();
        bus.m_awready = 1'b1;
        #1; chk("t2_hs_awready", bus.s_awready, 2'b01);
        cyc();
        bus.s_awvalid = 2'b10;
        #1; chk("t2_next_sel", bus.aw_sel, 1);
        cyc();
        clr();
        wdrain(3);
        bret(0); bret(0); bret(1);

        // AW order 1 then 0, master 0 presents W early
        bus.s_awvalid = 2'b10; bus.m_awready = 1'b1;
        bus.s_wvalid = 2'b01; bus.m_wready = 1'b1;
        #1; chk("t3_aw1", bus.aw_sel, 1);
        chk("t3_w_empty", bus.s_wready, 0);
        cyc();
        bus.s_awvalid = 2'b01;
        #1; chk("t3_aw0", bus.aw_sel, 0);
        chk("t3_w0_stall", bus.s_wready[0], 0);
        cyc();
        bus.s_awvalid = '0; bus.m_awready = 1'b0;
        bus.s_wvalid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            bus.s_wlast = (k == 3) ? 2'b10 : 2'b00;
            #1; chk("t3_m1_beat_wsel", bus.w_sel, 1);
            chk("t3_w0_blocked", bus.s_wready[0], 0);
            cyc();
        end
        bus.s_wvalid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            bus.s_wlast = (k == 3) ? 2'b01 : 2'b00;
            #1; chk("t3_m0_beat", bus.s_wready, 2'b01);
            cyc();
        end
        clr();
        #1; chk("t3_fifo_empty", bus.m_wvalid, 0);
        bret(1); bret(0);

        // Outstanding limit on master 0
        bus.s_awvalid = 2'b01; bus.m_awready = 1'b1;
        bus.s_wvalid = 2'b01; bus.s_wlast = 2'b01; bus.m_wready = 1'b1;
        repeat (8) cyc();
        #1; chk("t4_limit_block", bus.m_awvalid, 0);
        chk("t4_osd0_full", bus.osd_cnt[0], 8);
        cyc();
        bus.m_bvalid = 1'b1; bus.b_tag = 1'b0; bus.s_bready = 2'b01;
        #1; chk("t4_bvalid", bus.s_bvalid, 2'b01);
        chk("t4_still_block", bus.m_awvalid, 0);
        cyc();
        bus.m_bvalid = 1'b0; bus.s_bready = '0;
        #1; chk("t4_osd0_7", bus.osd_cnt[0], 7);
        chk("t4_regrant", bus.m_awvalid, 1);
        cyc();
        bus.s_awvalid = '0;
        cyc();
        clr();
        repeat (8) bret(0);
        #1; chk("t4_osd0_zero", bus.osd_cnt[0], 0);

        // FIFO full with a pop in the same cycle still blocks the push
        bus.s_awvalid = 2'b11; bus.m_awready = 1'b1;
        repeat (4) cyc();
        bus.s_wvalid = 2'b11; bus.s_wlast = 2'b11; bus.m_wready = 1'b1;
        #1; chk("t5_full_block", bus.m_awvalid, 0);
        cyc();
        #1; chk("t5_after_pop", bus.m_awvalid, 1);
        chk("t5_after_pop_sel", bus.aw_sel, 1);
        cyc();
        bus.s_awvalid = '0; bus.m_awready = 1'b0;
        repeat (3) cyc();
        clr();
        bret(1); bret(1); bret(1); bret(0); bret(0);

`ifdef AXI_WR_SCHED_QOS_EN
        // QoS priority, then round-robin on a tie
        bus.s_awqos[0] = 4'd2; bus.s_awqos[1] = 4'd9;
        bus.s_awvalid = 2'b11; bus.m_awready = 1'b1;
        bus.s_wvalid = 2'b11; bus.s_wlast = 2'b11; bus.m_wready = 1'b1;
        repeat (3) begin
            #1; chk("t7_qos_win", bus.aw_sel, 1);
            cyc();
        end
        bus.s_awqos[0] = 4'd5; bus.s_awqos[1] = 4'd5;
        for (int k = 0; k < 4; k++) begin
            #1; chk("t7_qos_tie", bus.aw_sel, k % 2);
            cyc();
        end
        bus.s_awvalid = '0; bus.m_awready = 1'b0;
        repeat (2) cyc();
        clr();
        repeat (5) bret(1);
        repeat (2) bret(0);
`endif

        // Unexpected B
        bus.m_bvalid = 1'b1; bus.b_tag = 1'b1; bus.s_bready = 2'b10;
        #1; chk("t6_bvalid1", bus.s_bvalid, 2'b10);
        chk("t6_bready", bus.m_bready, 1);
        cyc();
        clr();
        #1; chk("t6_err_set", bus.err_unexp_b, 1);
        chk("t6_osd1_zero", bus.osd_cnt[1], 0);
        repeat (3) cyc();
        chk("t6_err_sticky", bus.err_unexp_b, 1);

        // Reset in the middle of a burst
        bus.s_awvalid = 2'b01; bus.m_awready = 1'b1;
        cyc();
        bus.s_awvalid = '0; bus.m_awready = 1'b0;
        bus.s_wvalid = 2'b01; bus.s_wlast = 2'b00; bus.m_wready = 1'b1;
        repeat (2) cyc();
        rst = 1'b1;
        #1; chk("t8_rst_wvalid", bus.m_wvalid, 0);
        chk("t8_rst_wready", bus.s_wready, 0);
        cyc();
        rst = 1'b0;
        bus.s_wlast = 2'b01;
        #1; chk("t8_no_partial", bus.m_wvalid, 0);
        chk("t8_err_clr", bus.err_unexp_b, 0);
        chk("t8_osd0_clr", bus.osd_cnt[0], 0);
        cyc();
        clr();
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
